midi_msg_decoder: RTL and testbench

- Sits directly downstream of the MIDI UART receiver.
- Consumes each received byte, tracks running status and assembles complete channel-voice messages.
- Presents each complete message as one decoded event, with a valid/ready handshake, to the voice allocator.
- Runs entirely in the CLOCK_25 domain; the UART's byteready is a multi-cycle level, so this block edge-detects it.

---
 rtl/midi_pkg.sv | 62 ++++++
 rtl/midi_evt_reg.sv | 78 +++++++
 rtl/midi_msg_decoder.sv | 119 +++++++++++
 tb/tb_midi_msg_decoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared encodings for the MIDI message decoder: event types, status
// nibbles, system message bytes, controller numbers and parser states.
package midi_pkg;

  // Decoded event types presented on evt_type
  localparam logic [2:0] EVT_NOTE_OFF = 3'd0;
  localparam logic [2:0] EVT_NOTE_ON  = 3'd1;
  localparam logic [2:0] EVT_POLY_AT  = 3'd2;
  localparam logic [2:0] EVT_CC       = 3'd3;
  localparam logic [2:0] EVT_PROG     = 3'd4;
  localparam logic [2:0] EVT_CHAN_AT  = 3'd5;
  localparam logic [2:0] EVT_PBEND    = 3'd6;
  localparam logic [2:0] EVT_ALL_OFF  = 3'd7;

  // Channel-voice status nibbles
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;
  localparam logic [3:0] ST_PBEND    = 4'hE;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  // Parser states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_D1 = 2'd1,
    S_WAIT_D2 = 2'd2,
    S_SYSEX   = 2'd3
  } state_e;

  // Program change and channel aftertouch carry a single data byte
  function automatic logic one_data_byte(input logic [3:0] nib);
    return (nib == ST_PROG) || (nib == ST_CHAN_AT);
  endfunction

  // Map a status nibble and its data bytes onto an event type
  function automatic logic [2:0] map_type(input logic [3:0] nib,
                                          input logic [6:0] d1,
                                          input logic [6:0] d2,
                                          input logic       alloff_en);
    logic [2:0] t;
    case (nib)
      ST_NOTE_OFF: t = EVT_NOTE_OFF;
      ST_NOTE_ON:  t = (d2 == 7'd0) ? EVT_NOTE_OFF : EVT_NOTE_ON;
      ST_POLY_AT:  t = EVT_POLY_AT;
      ST_CC:       t = (alloff_en && (d1 == CC_ALL_SOUND_OFF || d1 == CC_ALL_NOTES_OFF))
                       ? EVT_ALL_OFF : EVT_CC;
      ST_PROG:     t = EVT_PROG;
      ST_CHAN_AT:  t = EVT_CHAN_AT;
      default:     t = EVT_PBEND;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/midi_evt_reg.sv
// One-deep event holding register with valid/ready handshake and a sticky
// overflow flag raised when a new event arrives while one is still stalled.
module midi_evt_reg
  import midi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [2:0] type_i,
  input  logic [3:0] chan_i,
  input  logic [6:0] d1_i,
  input  logic [6:0] d2_i,
  input  logic       ready_i,
  input  logic       clr_i,
  output logic       valid_o,
  output logic [2:0] type_o,
  output logic [3:0] chan_o,
  output logic [6:0] d1_o,
  output logic [6:0] d2_o,
  output logic       ovf_o
);

  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic [2:0] type_q, type_d;
  logic [3:0] chan_q, chan_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] d2_q, d2_d;

  // Load when empty or draining this cycle; otherwise drop and flag overflow
  always_comb begin
    valid_d = valid_q;
    type_d  = type_q;
    chan_d  = chan_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    if (load_i && (!valid_q || ready_i)) begin
      valid_d = 1'b1;
      type_d  = type_i;
      chan_d  = chan_i;
      d1_d    = d1_i;
      d2_d    = d2_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // Clear wins over a simultaneous overflow
    if (clr_i)                                ovf_d = 1'b0;
    else if (load_i && valid_q && !ready_i)   ovf_d = 1'b1;
    else                                      ovf_d = ovf_q;
  end

  // Holding register state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      type_q  <= 3'd0;
      chan_q  <= 4'd0;
      d1_q    <= 7'd0;
      d2_q    <= 7'd0;
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      type_q  <= type_d;
      chan_q  <= chan_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
  assign type_o  = type_q;
  assign chan_o  = chan_q;
  assign d1_o    = d1_q;
  assign d2_o    = d2_q;

endmodule

// File: rtl/midi_msg_decoder.sv
// MIDI channel-voice message decoder: edge-detects UART byteready, tracks
// running status and SysEx, and emits one decoded event per message.
// Optional: define MIDI_ALLOFF_EN to report CC 120/123 as ALL_OFF events.
module midi_msg_decoder
  import midi_pkg::*;
#(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       CLOCK_25,
  input  logic       iRST_N,
  input  logic       byteready,
  input  logic [7:0] midibyte,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_type,
  output logic [3:0] evt_chan,
  output logic [6:0] evt_d1,
  output logic [6:0] evt_d2,
  output logic       evt_ovf,
  input  logic       ovf_clr
);

`ifdef MIDI_ALLOFF_EN
  localparam logic ALLOFF_EN = 1'b1;
`else
  localparam logic ALLOFF_EN = 1'b0;
`endif

  logic       br_q;
  logic       stb;
  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;

  logic       cmp;
  logic       accept;
  logic [6:0] ev_d1, ev_d2;
  logic [2:0] ev_type;

  // One strobe per byte: rising edge of the multi-cycle byteready level
  assign stb = byteready & ~br_q;

  // State register, running status and first data byte
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      br_q     <= 1'b0;
      state_q  <= S_IDLE;
      status_q <= 8'h00;
      d1_q     <= 7'd0;
    end else begin
      br_q     <= byteready;
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
    end
  end

  // Next-state: status bytes redirect the parser, data bytes advance it
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    if (stb) begin
      if (midibyte[7]) begin
        if (midibyte == SYSEX_START) begin
          state_d  = S_SYSEX;
          status_d = 8'h00;
        end else if (midibyte[7:4] == 4'hF && midibyte <= SYSEX_END) begin
          state_d  = S_IDLE;
          status_d = 8'h00;
        end else if (midibyte[7:4] != 4'hF) begin
          state_d  = S_WAIT_D1;
          status_d = midibyte;
        end
        // F8-FF are real-time bytes and leave the parser untouched
      end else begin
        case (state_q)
          S_WAIT_D1: begin
            d1_d    = midibyte[6:0];
            state_d = one_data_byte(status_q[7:4]) ? S_WAIT_D1 : S_WAIT_D2;
          end
          S_WAIT_D2: state_d = S_WAIT_D1;
          default:   state_d = state_q;
        endcase
      end
    end
  end

  // Outputs: completion strobe, channel filter and decoded event fields
  always_comb begin
    cmp     = stb && !midibyte[7] &&
              ((state_q == S_WAIT_D1 && one_data_byte(status_q[7:4])) ||
               (state_q == S_WAIT_D2));
    accept  = OMNI || (status_q[3:0] == CHANNEL);
    ev_d1   = (state_q == S_WAIT_D1) ? midibyte[6:0] : d1_q;
    ev_d2   = (state_q == S_WAIT_D2) ? midibyte[6:0] : 7'd0;
    ev_type = map_type(status_q[7:4], ev_d1, ev_d2, ALLOFF_EN);
  end

  midi_evt_reg u_evt_reg (
    .clk_i   (CLOCK_25),
    .rst_ni  (iRST_N),
    .load_i  (cmp && accept),
    .type_i  (ev_type),
    .chan_i  (status_q[3:0]),
    .d1_i    (ev_d1),
    .d2_i    (ev_d2),
    .ready_i (evt_ready),
    .clr_i   (ovf_clr),
    .valid_o (evt_valid),
    .type_o  (evt_type),
    .chan_o  (evt_chan),
    .d1_o    (evt_d1),
    .d2_o    (evt_d2),
    .ovf_o   (evt_ovf)
  );

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Testbench for midi_msg_decoder: an omni instance and a channel-3 filtered
// instance share one byte stream and are checked against a message-level model.
module tb_midi_msg_decoder;

`ifdef MIDI_ALLOFF_EN
  localparam logic       ALLOFF = 1'b1;
  localparam logic [2:0] CC_OFF_T = 3'd7;
`else
  localparam logic       ALLOFF = 1'b0;
  localparam logic [2:0] CC_OFF_T = 3'd3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       br;
  logic [7:0] mb;
  logic       rdy;
  logic       clr;

  logic       v0, v1, o0, o1;
  logic [2:0] t0, t1;
  logic [3:0] c0, c1;
  logic [6:0] a0, a1, b0, b1;

  int n_assert = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  midi_msg_decoder dut (
    .CLOCK_25(clk), .iRST_N(rst_n), .byteready(br), .midibyte(mb),
    .evt_ready(rdy), .evt_valid(v0), .evt_type(t0), .evt_chan(c0),
    .evt_d1(a0), .evt_d2(b0), .evt_ovf(o0), .ovf_clr(clr)
  );

  midi_msg_decoder #(.OMNI(1'b0), .CHANNEL(4'd3)) dutf (
    .CLOCK_25(clk), .iRST_N(rst_n), .byteready(br), .midibyte(mb),
    .evt_ready(rdy), .evt_valid(v1), .evt_type(t1), .evt_chan(c1),
    .evt_d1(a1), .evt_d2(b1), .evt_ovf(o1), .ovf_clr(clr)
  );

  // ---------------- reference model ----------------
  logic       m_br;
  int         m_rs[2];
  int         m_nd[2];
  int         m_d1[2];
  logic       m_v[2];
  int         m_t[2], m_c[2], m_a[2], m_b[2];
  logic       m_ovf[2];
  int         ev_cnt[2];
  int         last_t, last_c, last_a, last_b;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_br = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_rs[k] = 0; m_nd[k] = 0; m_d1[k] = 0; m_v[k] = 1'b0; m_ovf[k] = 1'b0;
      m_t[k] = 0; m_c[k] = 0; m_a[k] = 0; m_b[k] = 0;
    end
  endtask

  function automatic int ev_type(input int nib, input int d1, input int d2);
    case (nib)
      8:  return 0;
      9:  return (d2 == 0) ? 0 : 1;
      10: return 2;
      11: return (ALLOFF && (d1 == 120 || d1 == 123)) ? 7 : 3;
      12: return 4;
      13: return 5;
      default: return 6;
    endcase
  endfunction

  // Advance the model by one clock using the inputs seen at this edge
  task automatic model_clock();
    logic stb;
    stb = br & ~m_br;
    m_br = br;
    for (int k = 0; k < 2; k++) begin
      logic comp;
      int ct, cc, ca, cb, need;
      comp = 1'b0; ct = 0; cc = 0; ca = 0; cb = 0;
      if (stb) begin
        if (mb >= 8'hF8) begin
        end else if (mb >= 8'hF0) begin
          m_rs[k] = 0; m_nd[k] = 0;
        end else if (mb >= 8'h80) begin
          m_rs[k] = mb; m_nd[k] = 0;
        end else if (m_rs[k] != 0) begin
          need = ((m_rs[k] >> 4) == 12 || (m_rs[k] >> 4) == 13) ? 1 : 2;
          if (m_nd[k] == 0) m_d1[k] = mb;
          m_nd[k]++;
          if (m_nd[k] == need) begin
            m_nd[k] = 0;
            cc = m_rs[k] & 15;
            ca = m_d1[k];
            cb = (need == 2) ? int'(mb) : 0;
            ct = ev_type(m_rs[k] >> 4, ca, cb);
            comp = (k == 0) || (cc == 3);
          end
        end
      end
      if (clr) m_ovf[k] = 1'b0;
      else if (comp && m_v[k] && !rdy) m_ovf[k] = 1'b1;
      if (comp && (!m_v[k] || rdy)) begin
        m_v[k] = 1'b1; m_t[k] = ct; m_c[k] = cc; m_a[k] = ca; m_b[k] = cb;
      end else if (m_v[k] && rdy) begin
        m_v[k] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid0", v0, m_v[0]);
    chk("ovf0", o0, m_ovf[0]);
    if (m_v[0]) begin
      chk("type0", t0, m_t[0]); chk("chan0", c0, m_c[0]);
      chk("d1_0", a0, m_a[0]);  chk("d2_0", b0, m_b[0]);
    end
    chk("valid1", v1, m_v[1]);
    chk("ovf1", o1, m_ovf[1]);
    if (m_v[1]) begin
      chk("type1", t1, m_t[1]); chk("chan1", c1, m_c[1]);
      chk("d1_1", a1, m_a[1]);  chk("d2_1", b1, m_b[1]);
    end
  endtask

  // One clock: drive, let the edge happen, update model, sample at negedge
  task automatic step(input logic b_r, input logic [7:0] b);
    br = b_r; mb = b;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
    if (v0 && rdy) begin
      ev_cnt[0]++; last_t = t0; last_c = c0; last_a = a0; last_b = b0;
    end
    if (v1 && rdy) ev_cnt[1]++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int hold, gap;
    hold = $urandom_range(2, 3);
    gap  = $urandom_range(1, 2);
    for (int i = 0; i < hold; i++) step(1'b1, b);
    for (int i = 0; i < gap; i++) step(1'b0, b);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_valid0"}, v0, 0); chk({nm, "_ovf0"}, o0, 0);
    chk({nm, "_fields0"}, {t0, c0, a0, b0}, 0);
    chk({nm, "_valid1"}, v1, 0); chk({nm, "_ovf1"}, o1, 0);
    chk({nm, "_fields1"}, {t1, c1, a1, b1}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    br = 1'b0; rst_n = 1'b0;
    #5;
    model_reset();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int             n;
    logic [4:0][7:0] b;
    int             ev0;
    int             ev1;
    int             t, c, d1, d2;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{3, {8'h92, 8'h3C, 8'h64, 8'h00, 8'h00}, 1, 0, 1, 2, 'h3C, 'h64};
    tbl[1]  = '{3, {8'h92, 8'h3C, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 2, 'h3C, 'h00};
    tbl[2]  = '{5, {8'h90, 8'h40, 8'h7F, 8'h41, 8'h7F}, 2, 0, 1, 0, 'h41, 'h7F};
    tbl[3]  = '{2, {8'hC5, 8'h07, 8'h00, 8'h00, 8'h00}, 1, 0, 4, 5, 'h07, 'h00};
    tbl[4]  = '{3, {8'hEF, 8'h00, 8'h40, 8'h00, 8'h00}, 1, 0, 6, 15, 'h00, 'h40};
    tbl[5]  = '{3, {8'hC5, 8'h07, 8'h09, 8'h00, 8'h00}, 2, 0, 4, 5, 'h09, 'h00};
    tbl[6]  = '{5, {8'hF0, 8'h41, 8'h10, 8'hF7, 8'h45}, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{5, {8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64}, 1, 0, 1, 0, 'h3C, 'h64};
    tbl[8]  = '{3, {8'hB0, 8'h7B, 8'h00, 8'h00, 8'h00}, 1, 0, int'(CC_OFF_T), 0, 'h7B, 'h00};
    tbl[9]  = '{3, {8'hA1, 8'h3C, 8'h20, 8'h00, 8'h00}, 1, 0, 2, 1, 'h3C, 'h20};
    tbl[10] = '{2, {8'hD4, 8'h55, 8'h00, 8'h00, 8'h00}, 1, 0, 5, 4, 'h55, 'h00};
    tbl[11] = '{3, {8'h83, 8'h3C, 8'h40, 8'h00, 8'h00}, 1, 1, 0, 3, 'h3C, 'h40};
    tbl[12] = '{3, {8'h91, 8'h3C, 8'h64, 8'h00, 8'h00}, 1, 0, 1, 1, 'h3C, 'h64};
    tbl[13] = '{3, {8'h93, 8'h3C, 8'h64, 8'h00, 8'h00}, 1, 1, 1, 3, 'h3C, 'h64};

    rst_n = 1'b0; br = 1'b0; mb = 8'h00; rdy = 1'b1; clr = 1'b0;
    ev_cnt[0] = 0; ev_cnt[1] = 0;
    last_t = 0; last_c = 0; last_a = 0; last_b = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;

    // Table-driven vectors with the consumer always ready
    for (int i = 0; i < 14; i++) begin
      ev_cnt[0] = 0; ev_cnt[1] = 0;
      for (int j = 0; j < tbl[i].n; j++) send_byte(tbl[i].b[4 - j]);
      repeat (3) step(1'b0, 8'h00);
      chk($sformatf("vec%0d_count", i), ev_cnt[0], tbl[i].ev0);
      chk($sformatf("vec%0d_count_ch3", i), ev_cnt[1], tbl[i].ev1);
      if (tbl[i].ev0 > 0)
        chk($sformatf("vec%0d_fields", i), {last_t, last_c, last_a, last_b},
            {tbl[i].t, tbl[i].c, tbl[i].d1, tbl[i].d2});
    end

    // Backpressure: second note dropped, overflow set, first held
    rdy = 1'b0;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h3E); send_byte(8'h64);
    chk("bp_valid", v0, 1);
    chk("bp_held", {t0, c0, a0, b0}, {3'd1, 4'd0, 7'h3C, 7'h64});
    chk("bp_ovf", o0, 1);
    // Clear and transfer in the same cycle
    rdy = 1'b1; clr = 1'b1;
    step(1'b0, 8'h00);
    chk("clr_ovf", o0, 0);
    chk("clr_xfer", v0, 0);
    rdy = 1'b0; clr = 1'b0;

    // Completion coincident with a transfer keeps valid high with new fields
    send_byte(8'h40); send_byte(8'h7F);
    chk("co_first", {v0, a0}, {1'b1, 7'h40});
    step(1'b1, 8'h42); step(1'b1, 8'h42); step(1'b0, 8'h42);
    rdy = 1'b1;
    step(1'b1, 8'h11);
    chk("co_valid", v0, 1);
    chk("co_fields", {a0, b0}, {7'h42, 7'h11});
    rdy = 1'b0;
    step(1'b1, 8'h11); step(1'b0, 8'h11);
    chk("co_noovf", o0, 0);
    rdy = 1'b1;
    repeat (2) step(1'b0, 8'h00);

    // Reset mid-message discards the partial note
    send_byte(8'h90); send_byte(8'h3C);
    do_reset();
    send_byte(8'h64);
    repeat (2) step(1'b0, 8'h00);
    chk("rst_partial", {v0, v1}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 45)      b = 8'($urandom_range(0, 127));
      else if (r < 78) b = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 82) b = 8'hF0;
      else if (r < 86) b = 8'hF7;
      else if (r < 93) b = 8'($urandom_range(8'hF8, 8'hFF));
      else             b = 8'($urandom_range(8'hF1, 8'hF6));
      rdy = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 19) == 0);
      send_byte(b);
    end
    rdy = 1'b1; clr = 1'b0;
    repeat (3) step(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
